// File: rtl/vga_sync_monitor.sv
// VGA sync timing monitor: measures line/frame geometry from hsync/vsync and reports lock.
// Define VGA_MON_ERRCNT_EN to add err_cnt, a saturating count of timing_err pulses.
`timescale 1ns/1ps
module vga_sync_monitor #(
    parameter int unsigned CNT_W       = 11,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter logic        HSYNC_POL   = 1'b0,
    parameter logic        VSYNC_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_sync_w,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_sync_w,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             locked,
    output logic             frame_start,
`ifdef VGA_MON_ERRCNT_EN
    output logic [7:0]       err_cnt,
`endif
    output logic             timing_err
);
    localparam int unsigned MC_W = (LOCK_FRAMES == 0) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam int unsigned FR_W = 4 * CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_e;

    state_e            state_q, state_d;
    logic              hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic              pend_q, pend_d, dev_q, dev_d;
    logic [CNT_W-1:0]  px_q, px_d, ln_q, ln_d, vcnt_q, vcnt_d;
    logic [CNT_W-1:0]  h_total_q, h_total_d, h_sync_w_q, h_sync_w_d;
    logic [CNT_W-1:0]  v_total_q, v_total_d, v_sync_w_q, v_sync_w_d;
    logic [FR_W-1:0]   st_q, st_d, new_frame;
    logic [MC_W-1:0]   match_q, match_d;
    logic [MC_W:0]     match_inc;
    logic              locked_q, fs_q, err_q, err_d, mism;
    logic              hs_act, vs_act, h_lead, h_trail, v_lead, v_trail, fs, timeout, frame_dev;
    logic [CNT_W-1:0]  line_len;

    // Edge detection works on activity, so polarity is resolved once here
    assign hs_act    = (hsync_in == HSYNC_POL);
    assign vs_act    = (vsync_in == VSYNC_POL);
    assign h_lead    = pix_en &  hs_act & ~hs_prev_q;
    assign h_trail   = pix_en & ~hs_act &  hs_prev_q;
    assign v_lead    = pix_en &  vs_act & ~vs_prev_q;
    assign v_trail   = pix_en & ~vs_act &  vs_prev_q;
    assign fs        = h_lead & (pend_q | v_lead);
    assign line_len  = (px_q == CNT_MAX) ? CNT_MAX : px_q + CNT_ONE;
    assign timeout   = pix_en & ~h_lead & (px_q == CNT_MAX - CNT_ONE);
    assign new_frame = {h_total_d, h_sync_w_d, v_total_d, v_sync_w_d};
    assign frame_dev = dev_q | (line_len != h_total_q);
    assign match_inc = {1'b0, match_q} + (MC_W + 1)'(1);

    always_comb begin
        hs_prev_d  = hs_prev_q;
        vs_prev_d  = vs_prev_q;
        px_d       = px_q;
        ln_d       = ln_q;
        vcnt_d     = vcnt_q;
        pend_d     = pend_q;
        dev_d      = dev_q;
        h_total_d  = h_total_q;
        h_sync_w_d = h_sync_w_q;
        v_total_d  = v_total_q;
        v_sync_w_d = v_sync_w_q;
        if (pix_en) begin
            hs_prev_d = hs_act;
            vs_prev_d = vs_act;
            if (h_lead)                px_d = '0;
            else if (px_q != CNT_MAX)  px_d = px_q + CNT_ONE;
            if (h_lead)  h_total_d  = line_len;
            if (h_trail) h_sync_w_d = px_d;
            if (v_lead)  pend_d     = 1'b1;
            if (fs) begin
                pend_d    = 1'b0;
                dev_d     = 1'b0;
                ln_d      = '0;
                v_total_d = (ln_q == CNT_MAX) ? CNT_MAX : ln_q + CNT_ONE;
                vcnt_d    = vs_act ? CNT_ONE : '0;
            end else if (h_lead) begin
                if (ln_q != CNT_MAX)               ln_d   = ln_q + CNT_ONE;
                if (vs_act && vcnt_q != CNT_MAX)   vcnt_d = vcnt_q + CNT_ONE;
                if (line_len != h_total_q)         dev_d  = 1'b1;
            end
            if (v_trail) v_sync_w_d = vcnt_q;
        end
    end

    // Lock FSM: next state, match counter, stored reference frame, error pulse
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        st_d    = st_q;
        err_d   = 1'b0;
        mism    = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (fs) begin
                    state_d = MEASURE;
                    match_d = '0;
                end
            end
            MEASURE: begin
                if (fs) begin
                    st_d = new_frame;
                    if (new_frame == st_q && !frame_dev) begin
                        if (32'(match_inc) >= LOCK_FRAMES) begin
                            state_d = LOCKED;
                            match_d = MC_W'(LOCK_FRAMES);
                        end else begin
                            match_d = match_inc[MC_W-1:0];
                        end
                    end else begin
                        match_d = MC_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (h_lead && line_len != st_q[FR_W-1 -: CNT_W]) mism = 1'b1;
                if (fs && new_frame != st_q)                     mism = 1'b1;
                if (fs) st_d = new_frame;
                if (mism) begin
                    err_d   = 1'b1;
                    state_d = MEASURE;
                    match_d = MC_W'(1);
                end
            end
            default: state_d = SEARCH;
        endcase
        if (timeout) begin
            state_d = SEARCH;
            match_d = '0;
            err_d   = (state_q == LOCKED);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= SEARCH;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
            pend_q     <= 1'b0;
            dev_q      <= 1'b0;
            px_q       <= '0;
            ln_q       <= '0;
            vcnt_q     <= '0;
            h_total_q  <= '0;
            h_sync_w_q <= '0;
            v_total_q  <= '0;
            v_sync_w_q <= '0;
            st_q       <= '0;
            match_q    <= '0;
            locked_q   <= 1'b0;
            fs_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            hs_prev_q  <= hs_prev_d;
            vs_prev_q  <= vs_prev_d;
            pend_q     <= pend_d;
            dev_q      <= dev_d;
            px_q       <= px_d;
            ln_q       <= ln_d;
            vcnt_q     <= vcnt_d;
            h_total_q  <= h_total_d;
            h_sync_w_q <= h_sync_w_d;
            v_total_q  <= v_total_d;
            v_sync_w_q <= v_sync_w_d;
            st_q       <= st_d;
            match_q    <= match_d;
            locked_q   <= (state_d == LOCKED);
            fs_q       <= fs;
            err_q      <= err_d;
        end
    end

`ifdef VGA_MON_ERRCNT_EN
    logic [7:0] err_cnt_q;
    always_ff @(posedge clk) begin
        if (rst)                               err_cnt_q <= '0;
        else if (err_d && err_cnt_q != 8'hFF)  err_cnt_q <= err_cnt_q + 8'd1;
    end
    assign err_cnt = err_cnt_q;
`endif

    assign h_total     = h_total_q;
    assign h_sync_w    = h_sync_w_q;
    assign v_total     = v_total_q;
    assign v_sync_w    = v_sync_w_q;
    assign x           = px_q;
    assign y           = ln_q;
    assign locked      = locked_q;
    assign frame_start = fs_q;
    assign timing_err  = err_q;

endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 11, giving the width of all counters and measurement outputs.
REQ-002 SHALL have parameter LOCK_FRAMES, default 2, giving the number of consecutive identical frames required to lock.
REQ-003 SHALL have parameter HSYNC_POL, default 0, giving the active level of hsync_in.
REQ-004 SHALL have parameter VSYNC_POL, default 0, giving the active level of vsync_in.
REQ-005 SHALL have port clk, input, 1 bit: single master clock (100 MHz); all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port pix_en, input, 1 bit: pixel strobe, high one clk per pixel.
REQ-008 SHALL have port hsync_in, input, 1 bit: horizontal sync under measurement.
REQ-009 SHALL have port vsync_in, input, 1 bit: vertical sync under measurement.
REQ-010 SHALL have port h_total, output, CNT_W bits: pixels per line.
REQ-011 SHALL have port h_sync_w, output, CNT_W bits: hsync active width in pixels.
REQ-012 SHALL have port v_total, output, CNT_W bits: lines per frame.
REQ-013 SHALL have port v_sync_w, output, CNT_W bits: vsync active width in lines.
REQ-014 SHALL have port x, output, CNT_W bits: pixel index since the hsync leading edge.
REQ-015 SHALL have port y, output, CNT_W bits: line index since the frame start.
REQ-016 SHALL have port locked, output, 1 bit: timing stable.
REQ-017 SHALL have port frame_start, output, 1 bit: one-clk pulse at each frame start.
REQ-018 SHALL have port timing_err, output, 1 bit: one-clk pulse on loss of lock.

Function
REQ-019 SHALL sample hsync_in/vsync_in only on clk edges with pix_en=1; all counters advance only on such samples.
REQ-020 SHALL define a leading edge as: current sample active (== *_POL) and previous sample inactive; trailing edge is the converse.
REQ-021 SHALL set the pixel counter to 0 on the hsync leading-edge sample and increment it on every other sample; x = pixel counter.
REQ-022 SHALL, at each hsync leading edge, latch h_total = previous counter value + 1.
REQ-023 SHALL, at each hsync trailing edge, latch h_sync_w = pixel counter value at that sample.
REQ-024 SHALL saturate the pixel counter at 2^CNT_W-1; saturation is a timeout: state -> SEARCH, locked=0, timing_err pulses if previously LOCKED.
REQ-025 SHALL, on a vsync leading edge, set frame_pending; frame start = first hsync leading edge with frame_pending set (same sample counts), which clears frame_pending.
REQ-026 SHALL, at frame start, latch v_total = line counter + 1, reset the line counter to 0, and pulse frame_start the following clk.
REQ-027 SHALL increment the line counter on every other hsync leading edge; y = line counter.
REQ-028 SHALL count vsync active width in hsync leading edges from frame start and latch v_sync_w at the vsync trailing edge.
REQ-029 SHALL implement FSM SEARCH -> MEASURE on the first frame start; MEASURE -> LOCKED; LOCKED -> MEASURE on mismatch; any state -> SEARCH on timeout.
REQ-030 SHALL, in MEASURE at each frame start, compare {h_total, h_sync_w, v_total, v_sync_w} with the stored previous frame; equal and no line-length deviation within the frame gives match_cnt+1, otherwise match_cnt=1; then store the new values.
REQ-031 SHALL enter LOCKED when match_cnt reaches LOCK_FRAMES; locked=1 from the same clk as the frame_start pulse.
REQ-032 SHALL, in LOCKED, treat any line length or frame value differing from the stored values as a mismatch: timing_err one-clk pulse, locked=0, state MEASURE, match_cnt=1.
REQ-033 SHALL leave the measurement outputs updating regardless of state; only locked qualifies them.

Reset
REQ-034 SHALL, on rst=1 at a clk edge, clear all outputs, counters, stored values, match_cnt and frame_pending to 0, set state SEARCH, and treat the previous samples as inactive; rst has priority over pix_en.

Configuration
REQ-035 SHALL, with VGA_MON_ERRCNT_EN defined, add output err_cnt (8 bits, reset 0) that increments on each timing_err and saturates at 255; without the macro the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 Standard 640x480 stream (800 px/line, 96 px hsync active-low, 525 lines, 2-line vsync), pix_en every 4th clk -> h_total=800, h_sync_w=96, v_total=525, v_sync_w=2; locked=1 at the 3rd frame_start.
REQ-037 While locked, one line shortened to 799 px -> single timing_err pulse and locked=0; locked=1 again at the 2nd subsequent frame start (with macro: err_cnt=1).
REQ-038 hsync held inactive -> after 2047 samples state SEARCH, locked=0, one timing_err pulse.
REQ-039 rst asserted mid-frame while locked -> next clk: all outputs 0, locked=0; relock after 3 frame starts.
REQ-040 HSYNC_POL=1, VSYNC_POL=1 with inverted stream -> same values as REQ-036.
REQ-041 vsync leading edge coinciding with an hsync leading-edge sample -> frame_start on that line, y=0 on that sample.
